// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: DEPTH slots carrying {data, ctrl} under valid/ready,
// with bubble collapsing, back-pressure and synchronous flush.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 2,
    parameter int DEPTH  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // Ready is combinational from out_ready and slot state; flush forces both sides idle.

    logic [DEPTH-1:0]  v_q, v_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [DEPTH-1:0]  move;
    logic [DEPTH-1:0]  acc;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Acceptance ripples from the output side so empty middle slots fill during a stall.
    always_comb begin
        move = '0;
        acc  = '0;
        move[DEPTH-1] = v_q[DEPTH-1] & out_ready;
        acc[DEPTH-1]  = ~v_q[DEPTH-1] | move[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            move[i] = v_q[i] & acc[i+1];
            acc[i]  = ~v_q[i] | move[i];
        end
    end

    assign in_ready = acc[0] & ~flush;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_d[i] = '0;
            end
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (acc[i] & v_q[i-1]) begin
                    v_d[i]    = 1'b1;
                    data_d[i] = data_q[i-1];
                    ctrl_d[i] = ctrl_q[i-1];
                end else if (move[i]) begin
                    v_d[i]    = 1'b0;
                    ctrl_d[i] = '0;
                end
            end
            if (in_valid & in_ready) begin
                v_d[0]    = 1'b1;
                data_d[0] = in_data;
                ctrl_d[0] = in_ctrl;
            end else if (move[0]) begin
                v_d[0]    = 1'b0;
                ctrl_d[0] = '0;
            end
        end
    end

    // Occupancy is registered from the next slot state so it always matches v_q.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v_d[i]) begin
                occ_d = occ_d + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ctrl_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                ctrl_q[i] <= ctrl_d[i];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign out_ctrl  = out_valid ? ctrl_q[DEPTH-1] : '0;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances (DEPTH 3, 2, 4, 1) share stimulus; sel picks
// which one the driver handshakes with and the scoreboard monitor checks.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ctrl;
    logic        out_ready;
    logic [1:0]  sel;

    logic        ir [4];
    logic        ov [4];
    logic [15:0] od [4];
    logic [1:0]  oc [4];
    logic [1:0]  occ_d3;
    logic [1:0]  occ_d2;
    logic [2:0]  occ_d4;
    logic [0:0]  occ_d1;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_data;
    logic [1:0]  s_out_ctrl;
    logic [3:0]  s_occ;

    logic [17:0] exp_q[$];
    int          checks;
    int          errors;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(2), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_ctrl(oc[0]), .occupancy(occ_d3));
    pipe_stage_reg #(.DATA_W(16), .CTRL_W(2), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_ctrl(oc[1]), .occupancy(occ_d2));
    pipe_stage_reg #(.DATA_W(16), .CTRL_W(2), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_ctrl(oc[2]), .occupancy(occ_d4));
    pipe_stage_reg #(.DATA_W(16), .CTRL_W(2), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[3]), .out_ready(out_ready),
        .out_data(od[3]), .out_ctrl(oc[3]), .occupancy(occ_d1));

    always_comb begin
        s_in_ready  = ir[sel];
        s_out_valid = ov[sel];
        s_out_data  = od[sel];
        s_out_ctrl  = oc[sel];
        case (sel)
            2'd0:    s_occ = {2'b00, occ_d3};
            2'd1:    s_occ = {2'b00, occ_d2};
            2'd2:    s_occ = {1'b0, occ_d4};
            default: s_occ = {3'b000, occ_d1};
        endcase
    end

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: inputs change just after the falling edge; an accepted beat goes to the scoreboard.
    task automatic drive(input logic iv, input logic [15:0] d, input logic [1:0] c,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #2;
        if (iv && s_in_ready) exp_q.push_back({c, d});
    endtask

    task automatic do_reset(input logic [1:0] which);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        sel       = which;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: samples shortly before each rising edge.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (s_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(s_out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(s_out_data), 32'(e[15:0]));
                    check("out_ctrl", 32'(s_out_ctrl), 32'(e[17:16]));
                end
            end else if (!s_out_valid) begin
                check("bubble_ctrl", 32'(s_out_ctrl), 32'h0);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        sel       = 2'd0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;

        #3;
        check("rst_out_valid", 32'(s_out_valid), 32'h0);
        check("rst_out_data", 32'(s_out_data), 32'h0);
        check("rst_occ", 32'(s_occ), 32'h0);
        check("rst_in_ready", 32'(s_in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Streaming through DEPTH=3
        do_reset(2'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'h0010 + 16'(k), 2'b11, 1'b1, 1'b0);
            check("stream_in_ready", 32'(s_in_ready), 32'h1);
            check("stream_latency", 32'(s_out_valid), (k >= 3) ? 32'h1 : 32'h0);
            if (k >= 3) check("stream_occ", 32'(s_occ), 32'h3);
        end
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("stream_occ_tail", 32'(s_occ), 32'h3);
        check("stream_data_tail", 32'(s_out_data), 32'h0012);
        for (int j = 0; j < 3; j++) drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("stream_drained", 32'(s_occ), 32'h0);

        // Back-pressure on DEPTH=2
        do_reset(2'd1);
        drive(1'b1, 16'h0020, 2'b01, 1'b0, 1'b0);
        check("bp_ready0", 32'(s_in_ready), 32'h1);
        drive(1'b1, 16'h0021, 2'b10, 1'b0, 1'b0);
        check("bp_ready1", 32'(s_in_ready), 32'h1);
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, 16'h0022, 2'b11, 1'b0, 1'b0);
            check("bp_ready_full", 32'(s_in_ready), 32'h0);
            check("bp_occ_full", 32'(s_occ), 32'h2);
            check("bp_data_held", 32'(s_out_data), 32'h0020);
            check("bp_ctrl_held", 32'(s_out_ctrl), 32'h1);
        end
        drive(1'b1, 16'h0022, 2'b11, 1'b1, 1'b0);
        check("bp_ready_release", 32'(s_in_ready), 32'h1);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("bp_occ_swap", 32'(s_occ), 32'h2);
        check("bp_data_next", 32'(s_out_data), 32'h0021);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("bp_drained", 32'(s_occ), 32'h0);

        // Bubble collapse on DEPTH=4
        do_reset(2'd2);
        drive(1'b1, 16'h0030, 2'b10, 1'b0, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
            check("bc_not_yet", 32'(s_out_valid), 32'h0);
        end
        drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
        check("bc_arrived", 32'(s_out_valid), 32'h1);
        check("bc_occ", 32'(s_occ), 32'h1);
        check("bc_data", 32'(s_out_data), 32'h0030);
        check("bc_ctrl", 32'(s_out_ctrl), 32'h2);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);

        // Flush on a full DEPTH=3
        do_reset(2'd0);
        drive(1'b1, 16'h0040, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 16'h0041, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 16'h0042, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 16'h0043, 2'b11, 1'b1, 1'b1);
        check("fl_in_ready", 32'(s_in_ready), 32'h0);
        check("fl_out_valid", 32'(s_out_valid), 32'h0);
        check("fl_out_ctrl", 32'(s_out_ctrl), 32'h0);
        check("fl_occ_before", 32'(s_occ), 32'h3);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("fl_occ_after", 32'(s_occ), 32'h0);
        check("fl_data_kept", 32'(s_out_data), 32'h0040);
        check("fl_ready_after", 32'(s_in_ready), 32'h1);
        exp_q.delete();

        // Bubble control masking and back-to-back on DEPTH=1
        do_reset(2'd3);
        drive(1'b1, 16'h0050, 2'b01, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("d1_valid", 32'(s_out_valid), 32'h1);
        check("d1_ctrl", 32'(s_out_ctrl), 32'h1);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("d1_bubble_valid", 32'(s_out_valid), 32'h0);
        check("d1_bubble_ctrl", 32'(s_out_ctrl), 32'h0);
        check("d1_bubble_data", 32'(s_out_data), 32'h0050);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 16'h0050 + 16'(k), 2'(k), 1'b1, 1'b0);
            check("d1_b2b_ready", 32'(s_in_ready), 32'h1);
        end
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("d1_b2b_occ", 32'(s_occ), 32'h1);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("d1_b2b_empty", 32'(s_out_valid), 32'h0);

        // Asynchronous reset mid-stream on DEPTH=3
        do_reset(2'd0);
        drive(1'b1, 16'h0060, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 16'h0061, 2'b10, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0);
        check("mr_occ_pre", 32'(s_occ), 32'h2);
        @(posedge clk);
        #2;
        check("mr_valid_pre", 32'(s_out_valid), 32'h1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mr_out_valid", 32'(s_out_valid), 32'h0);
        check("mr_out_ctrl", 32'(s_out_ctrl), 32'h0);
        check("mr_out_data", 32'(s_out_data), 32'h0);
        check("mr_occ", 32'(s_occ), 32'h0);
        check("mr_in_ready", 32'(s_in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register replacing the fixed, per-boundary stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a generic data payload plus a control field through DEPTH register slots under a valid/ready handshake. Supports back-pressure (stall), bubble collapsing and synchronous flush. Control bits (RegWrite, MemToReg, etc.) are zeroed at the output whenever no valid instruction is presented, so bubbles cannot cause architectural side effects.

## Interface
- DATA_W, 64: payload width (address, data, register target, …), not cleared on bubble
- CTRL_W, 2: control-field width, forced to 0 when the slot is invalid
- DEPTH, 1: number of register slots, legal range 1..8
- clk  in  1: clock, all state changes on rising edge
- rst  in  1: asynchronous, active-high reset
- flush  in  1: synchronous squash of all slots
- in_valid  in  1: upstream presents an instruction
- in_ready  out  1: block accepts the upstream instruction this cycle
- in_data  in  DATA_W: upstream payload
- in_ctrl  in  CTRL_W: upstream control bits
- out_valid  out  1: last slot holds a valid instruction
- out_ready  in  1: downstream consumes this cycle
- out_data  out  DATA_W: last-slot payload
- out_ctrl  out  CTRL_W: last-slot control bits, 0 when out_valid=0
- occupancy  out  clog2(DEPTH+1): number of valid slots

## Operation
- Slots indexed 0 (input side) to DEPTH-1 (output side). Each slot holds v[i], data[i], ctrl[i].
- move[DEPTH-1] = v[DEPTH-1] & out_ready. move[i] = v[i] & acc[i+1].
- acc[i] = !v[i] | move[i]. A slot accepts when empty or when it drains this cycle (bubble collapsing: empty middle slots fill without waiting on downstream).
- in_ready = acc[0] & !flush. Combinational from out_ready and the v[] state. No registered ready path.
- On each edge without flush:
  - Slot i>0 loads {v,data,ctrl} from slot i-1 when acc[i] & v[i-1].
  - Slot i>0 clears v[i] when move[i] and it is not being refilled.
  - Slot 0 loads from the input when in_valid & in_ready.
  - Slot 0 clears when move[0] without a new input.
- Invalid slots keep stale data[i]. ctrl[i] is written to 0 whenever v[i] becomes 0.
- out_valid = v[DEPTH-1] & !flush.
- out_data = data[DEPTH-1], held while stalled.
- out_ctrl = out_valid ? ctrl[DEPTH-1] : 0.
- flush = 1:
  - in_ready = 0 and out_valid = 0 in that cycle, so neither handshake completes.
  - On the edge, all v[] and ctrl[] are cleared; data[] is unchanged.
  - Flush overrides in_valid and out_ready.
- Stall: while out_ready = 0 with all slots full, no slot changes and in_ready = 0. Payload is held bit-exact.
- occupancy = popcount(v[]), registered with the slots and consistent with them after every edge.

## Timing
- Reset (async assert, any time, including mid-transfer): all v = 0, data = 0, ctrl = 0, so out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0, in_ready = 1. Deassertion is synchronous to the design's reset release and needs no extra cycle.
- Latency: an instruction accepted at edge N into an empty pipe is at the output (out_valid = 1) after edge N+DEPTH-1, i.e. DEPTH cycles from the input handshake to the output handshake opportunity.
- Throughput: 1 instruction/cycle with out_ready held high. With DEPTH=1 and out_ready = 1, full back-to-back transfer works (accept and drain on the same edge).
- Simultaneous input and output handshake on a full pipe: occupancy unchanged and data shifts by one slot.
- Ordering is strictly FIFO; no duplication, no loss.

## Test plan
- Reset mid-stream: DEPTH=3, fill 2 slots, assert rst asynchronously between edges -> out_valid, out_ctrl, out_data, occupancy read 0 immediately; in_ready = 1.
- Streaming: DEPTH=3, out_ready = 1, inputs data 0x10..0x14 with ctrl 2'b11 on consecutive cycles -> out_valid first high 3 cycles after the first accept, then 0x10..0x14 on consecutive cycles, occupancy steady at 3.
- Back-pressure: DEPTH=2, out_ready = 0, present 3 inputs -> first two accepted, in_ready = 0 on the third, occupancy = 2, out_data held at the first value; raise out_ready -> third accepted the same cycle the first drains.
- Bubble collapse: DEPTH=4, out_ready = 0, one input -> it reaches slot 3 after 3 edges despite the stall; occupancy = 1.
- Flush: DEPTH=3 full with ctrl 2'b11, pulse flush with in_valid = 1 and out_ready = 1 -> in that cycle in_ready = 0, out_valid = 0, out_ctrl = 0; after the edge occupancy = 0 and out_data is unchanged.
- Bubble control masking: DEPTH=1, single input ctrl 2'b01, out_ready = 1, then in_valid = 0 -> next cycle out_valid = 0, out_ctrl = 2'b00, out_data still holds the last payload.
